// File: rtl/tour_pkg.sv
// Shared constants and state encoding for the knight's-tour command replayer.
package tour_pkg;

    // Headings understood by the downstream command processor
    localparam logic [7:0] HEAD_NORTH = 8'h00;
    localparam logic [7:0] HEAD_WEST  = 8'h3F;
    localparam logic [7:0] HEAD_SOUTH = 8'h7F;
    localparam logic [7:0] HEAD_EAST  = 8'hBF;

    // Command opcodes: the horizontal leg ends a knight move, so it plays the fanfare
    localparam logic [3:0] OP_MOVE     = 4'h2;
    localparam logic [3:0] OP_MOVE_FAN = 4'h3;

    // Response bytes returned to the host
    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    // Index of the last move of a 5x5 tour (25 squares -> 24 moves)
    localparam logic [4:0] LAST_MOVE = 5'd23;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        WAIT_V,
        HORZ,
        WAIT_H
    } tour_state_t;

    // Magnitude of a signed 3-bit displacement as a 4-bit square count
    function automatic logic [3:0] abs_squares(input logic signed [2:0] v);
        logic [2:0] u;
        u = v[2] ? (~v + 3'd1) : v;
        return {1'b0, u};
    endfunction

endpackage

// File: rtl/tour_move_decode.sv
// Converts a one-hot knight move into signed (dx, dy) displacements.
// A non-one-hot code resolves to its lowest set bit; all-zero gives (0, 0).
module tour_move_decode (
    input  logic [7:0]        move,
    output logic signed [2:0] dx,
    output logic signed [2:0] dy
);

    // Priority decode, lowest set bit first
    always_comb begin
        dx = 3'sb000;
        dy = 3'sb000;
        casez (move)
            8'b???????1: begin dx = 3'sb001; dy = 3'sb010; end  // +1,+2
            8'b??????10: begin dx = 3'sb111; dy = 3'sb010; end  // -1,+2
            8'b?????100: begin dx = 3'sb110; dy = 3'sb001; end  // -2,+1
            8'b????1000: begin dx = 3'sb110; dy = 3'sb111; end  // -2,-1
            8'b???10000: begin dx = 3'sb111; dy = 3'sb110; end  // -1,-2
            8'b??100000: begin dx = 3'sb001; dy = 3'sb110; end  // +1,-2
            8'b?1000000: begin dx = 3'sb010; dy = 3'sb111; end  // +2,-1
            8'b10000000: begin dx = 3'sb010; dy = 3'sb001; end  // +2,+1
            default:     begin dx = 3'sb000; dy = 3'sb000; end
        endcase
    end

endmodule

// File: rtl/tour_cmd.sv
// Replays a solved knight's tour as pairs of drive commands (vertical leg,
// then horizontal leg with fanfare), and otherwise passes UART commands through.
module tour_cmd
    import tour_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic [7:0]  resp
);

    tour_state_t state_reg, state_next;
    logic [4:0]  mv_indx_reg, mv_indx_next;

    logic signed [2:0] dx, dy;
    logic [15:0]       vert_cmd, horz_cmd;
    logic              move_none;

    tour_move_decode u_decode (
        .move (move),
        .dx   (dx),
        .dy   (dy)
    );

    // The move input is indexed by mv_indx, so both legs stay constant for
    // the whole handshake without needing a command holding register.
    assign vert_cmd  = {OP_MOVE,     (dy[2] ? HEAD_SOUTH : HEAD_NORTH), abs_squares(dy)};
    assign horz_cmd  = {OP_MOVE_FAN, (dx[2] ? HEAD_WEST  : HEAD_EAST),  abs_squares(dx)};
    assign move_none = (move == 8'h00);
    assign mv_indx   = mv_indx_reg;

    // State and move-index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            mv_indx_reg <= 5'd0;
        end else begin
            state_reg   <= state_next;
            mv_indx_reg <= mv_indx_next;
        end
    end

    // Next-state logic and command mux
    always_comb begin
        state_next       = state_reg;
        mv_indx_next     = mv_indx_reg;
        cmd              = 16'h0000;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = RESP_BUSY;
        case (state_reg)
            IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = RESP_DONE;
                if (start_tour) begin
                    mv_indx_next = 5'd0;
                    state_next   = VERT;
                end
            end
            VERT: begin
                // An empty move means the solver had nothing to give: give up quietly
                if (move_none) begin
                    state_next = IDLE;
                end else begin
                    cmd     = vert_cmd;
                    cmd_rdy = 1'b1;
                    if (clr_cmd_rdy)
                        state_next = WAIT_V;
                end
            end
            WAIT_V: begin
                cmd = vert_cmd;
                if (send_resp)
                    state_next = HORZ;
            end
            HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy)
                    state_next = WAIT_H;
            end
            WAIT_H: begin
                cmd = horz_cmd;
                if (mv_indx_reg == LAST_MOVE)
                    resp = RESP_DONE;
                if (send_resp) begin
                    if (mv_indx_reg == LAST_MOVE) begin
                        state_next = IDLE;
                    end else begin
                        mv_indx_next = mv_indx_reg + 5'd1;
                        state_next   = VERT;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tour_cmd.sv
// Self-checking bench for tour_cmd: randomized tours checked against a
// displacement-table reference model.
module tb_tour_cmd;

    logic        clk;
    logic        rst_n;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic [7:0]  resp;

    int tests_run;
    int tests_failed;

    // Solver memory: the bench plays the tour solver, answering mv_indx
    logic [7:0] tour_moves [0:31];
    assign move = tour_moves[mv_indx];

    // Knight displacements per move bit
    int dx_tab [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int dy_tab [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

    tour_cmd dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_tour       (start_tour),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .resp             (resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lowest_bit(input logic [7:0] m);
        for (int i = 0; i < 8; i++)
            if (m[i]) return i;
        return 0;
    endfunction

    function automatic logic [15:0] exp_vert(input logic [7:0] m);
        int d;
        d = dy_tab[lowest_bit(m)];
        return {4'h2, (d > 0) ? 8'h00 : 8'h7F, 4'(d < 0 ? -d : d)};
    endfunction

    function automatic logic [15:0] exp_horz(input logic [7:0] m);
        int d;
        d = dx_tab[lowest_bit(m)];
        return {4'h3, (d > 0) ? 8'hBF : 8'h3F, 4'(d < 0 ? -d : d)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
    endtask

    task automatic clear_moves();
        for (int i = 0; i < 32; i++) tour_moves[i] = 8'h00;
    endtask

    // One full knight move from VERT entry; optionally stops in WAIT_H
    task automatic do_move(input int idx, input bit stop_in_wait_h);
        logic [15:0] ev, eh;
        int n;
        ev = exp_vert(tour_moves[idx]);
        eh = exp_horz(tour_moves[idx]);
        $display("[TB] move %0d: code %h -> vert %h horz %h", idx, tour_moves[idx], ev, eh);
        tests_run++;
        if (cmd_rdy !== 1'b1 || cmd !== ev || mv_indx !== 5'(idx) || resp !== 8'h5A) begin
            tests_failed++;
            $display("FAIL vert_cmd idx %0d: cmd %h rdy %b mv %0d resp %h, want cmd %h rdy 1 mv %0d resp 5a",
                     idx, cmd, cmd_rdy, mv_indx, resp, ev, idx);
        end
        n = $urandom_range(0, 2);
        repeat (n) tick();
        tests_run++;
        if (cmd_rdy !== 1'b1 || cmd !== ev) begin
            tests_failed++;
            $display("FAIL vert_hold idx %0d: cmd %h rdy %b, want %h rdy 1", idx, cmd, cmd_rdy, ev);
        end
        clr_cmd_rdy = 1'b1;
        #1;
        tests_run++;
        if (clr_cmd_rdy_UART !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_leak idx %0d: clr_cmd_rdy_UART %b, want 0", idx, clr_cmd_rdy_UART);
        end
        tick();
        clr_cmd_rdy = 1'b0;
        tests_run++;
        if (cmd_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL wait_v idx %0d: cmd_rdy %b, want 0", idx, cmd_rdy);
        end
        repeat ($urandom_range(0, 2)) tick();
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        tests_run++;
        if (cmd_rdy !== 1'b1 || cmd !== eh) begin
            tests_failed++;
            $display("FAIL horz_cmd idx %0d: cmd %h rdy %b, want %h rdy 1", idx, cmd, cmd_rdy, eh);
        end
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        tests_run++;
        if (cmd_rdy !== 1'b0 || resp !== ((idx == 23) ? 8'hA5 : 8'h5A)) begin
            tests_failed++;
            $display("FAIL wait_h idx %0d: cmd_rdy %b resp %h, want 0 and %h",
                     idx, cmd_rdy, resp, (idx == 23) ? 8'hA5 : 8'h5A);
        end
        if (!stop_in_wait_h) begin
            send_resp = 1'b1;
            tick();
            send_resp = 1'b0;
            tests_run++;
            if (idx == 23) begin
                if (mv_indx !== 5'd23 || resp !== 8'hA5 || cmd_rdy !== cmd_rdy_UART || cmd !== cmd_UART) begin
                    tests_failed++;
                    $display("FAIL tour_end: mv %0d resp %h rdy %b cmd %h, want 23 a5 %b %h",
                             mv_indx, resp, cmd_rdy, cmd, cmd_rdy_UART, cmd_UART);
                end
            end else if (mv_indx !== 5'(idx + 1)) begin
                tests_failed++;
                $display("FAIL mv_next idx %0d: mv_indx %0d, want %0d", idx, mv_indx, idx + 1);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_UART = 16'h1234;
        cmd_rdy_UART = 1'b1;
        repeat (3) tick();
        tests_run++;
        if (mv_indx !== 5'd0 || resp !== 8'hA5 || cmd_rdy !== 1'b1 || cmd !== 16'h1234) begin
            tests_failed++;
            $display("FAIL reset_state: mv %0d resp %h rdy %b cmd %h, want 0 a5 1 1234",
                     mv_indx, resp, cmd_rdy, cmd);
        end
        rst_n = 1'b1;
        repeat (4) tick();
        tests_run++;
        if (resp !== 8'hA5 || cmd_rdy !== 1'b1 || mv_indx !== 5'd0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: resp %h rdy %b mv %0d, want a5 1 0", resp, cmd_rdy, mv_indx);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_passthrough();
        logic [15:0] c;
        logic        r, k;
        cmd_UART = 16'h2004;
        cmd_rdy_UART = 1'b1;
        clr_cmd_rdy = 1'b1;
        #1;
        tests_run++;
        if (cmd !== 16'h2004 || cmd_rdy !== 1'b1 || clr_cmd_rdy_UART !== 1'b1) begin
            tests_failed++;
            $display("FAIL passthrough: cmd %h rdy %b clr %b, want 2004 1 1", cmd, cmd_rdy, clr_cmd_rdy_UART);
        end
        tick();
        clr_cmd_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            c = 16'($urandom);
            r = 1'($urandom);
            k = 1'($urandom);
            cmd_UART = c;
            cmd_rdy_UART = r;
            clr_cmd_rdy = k;
            #1;
            tests_run++;
            if (cmd !== c || cmd_rdy !== r || clr_cmd_rdy_UART !== k) begin
                tests_failed++;
                $display("FAIL passthrough_rand: cmd %h rdy %b clr %b, want %h %b %b",
                         cmd, cmd_rdy, clr_cmd_rdy_UART, c, r, k);
            end
            $display("[TB] passthrough cmd %h rdy %b clr %b", c, r, k);
            tick();
        end
        clr_cmd_rdy = 1'b0;
        cmd_rdy_UART = 1'b1;
        cmd_UART = 16'hDEAD;
    endtask

    task automatic test_single_move();
        clear_moves();
        tour_moves[0] = 8'h01;
        pulse_start();
        tests_run++;
        if (cmd !== 16'h2002) begin
            tests_failed++;
            $display("FAIL single_vert: cmd %h, want 2002", cmd);
        end
        do_move(0, 1'b0);
        tests_run++;
        if (mv_indx !== 5'd1) begin
            tests_failed++;
            $display("FAIL single_idx: mv_indx %0d, want 1", mv_indx);
        end
        tick();  // zero move at index 1 aborts back to IDLE
    endtask

    task automatic test_south_west();
        clear_moves();
        tour_moves[0] = 8'h10;
        pulse_start();
        tests_run++;
        if (cmd !== 16'h27F2) begin
            tests_failed++;
            $display("FAIL sw_vert: cmd %h, want 27f2", cmd);
        end
        do_move(0, 1'b0);
        tick();
    endtask

    task automatic test_full_tour();
        clear_moves();
        for (int i = 0; i < 24; i++)
            tour_moves[i] = (i % 3 == 2) ? 8'($urandom_range(1, 255)) : (8'h01 << $urandom_range(0, 7));
        pulse_start();
        for (int i = 0; i < 24; i++) do_move(i, 1'b0);
        tick();
        tests_run++;
        if (mv_indx !== 5'd23 || resp !== 8'hA5) begin
            tests_failed++;
            $display("FAIL tour_idle: mv %0d resp %h, want 23 a5", mv_indx, resp);
        end
    endtask

    task automatic test_simultaneous();
        logic [15:0] eh;
        clear_moves();
        tour_moves[0] = 8'h01 << $urandom_range(0, 7);
        eh = exp_horz(tour_moves[0]);
        pulse_start();
        clr_cmd_rdy = 1'b1;
        send_resp = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b0;
        tick();
        tests_run++;
        if (cmd_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL both_in_vert: cmd_rdy %b, want 0 (WAIT_V)", cmd_rdy);
        end
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        tests_run++;
        if (cmd_rdy !== 1'b1 || cmd !== eh) begin
            tests_failed++;
            $display("FAIL clr_in_wait_v: cmd %h rdy %b, want %h 1", cmd, cmd_rdy, eh);
        end
        send_resp = 1'b1;
        start_tour = 1'b1;
        tick();
        send_resp = 1'b0;
        start_tour = 1'b0;
        tests_run++;
        if (cmd_rdy !== 1'b1 || cmd !== eh || mv_indx !== 5'd0) begin
            tests_failed++;
            $display("FAIL resp_in_horz: cmd %h rdy %b mv %0d, want %h 1 0", cmd, cmd_rdy, mv_indx, eh);
        end
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        // Now in VERT at index 1 where the solver offers no move
        tests_run++;
        if (cmd_rdy !== 1'b0 || mv_indx !== 5'd1) begin
            tests_failed++;
            $display("FAIL zero_move: cmd_rdy %b mv %0d, want 0 1", cmd_rdy, mv_indx);
        end
        tick();
        tests_run++;
        if (resp !== 8'hA5 || mv_indx !== 5'd1 || cmd_rdy !== cmd_rdy_UART) begin
            tests_failed++;
            $display("FAIL zero_abort: resp %h mv %0d rdy %b, want a5 1 %b", resp, mv_indx, cmd_rdy, cmd_rdy_UART);
        end
        $display("[TB] simultaneous events and zero move checked");
    endtask

    task automatic test_mid_reset();
        clear_moves();
        for (int i = 0; i < 8; i++) tour_moves[i] = 8'h01 << $urandom_range(0, 7);
        pulse_start();
        for (int i = 0; i < 7; i++) do_move(i, 1'b0);
        do_move(7, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (mv_indx !== 5'd0 || resp !== 8'hA5 || cmd_rdy !== cmd_rdy_UART || cmd !== cmd_UART) begin
            tests_failed++;
            $display("FAIL mid_reset: mv %0d resp %h rdy %b cmd %h, want 0 a5 %b %h",
                     mv_indx, resp, cmd_rdy, cmd, cmd_rdy_UART, cmd_UART);
        end
        tick();
        rst_n = 1'b1;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        tests_run++;
        if (resp !== 8'hA5 || mv_indx !== 5'd0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: resp %h mv %0d, want a5 0", resp, mv_indx);
        end
        $display("[TB] mid-tour reset checked");
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        start_tour = 1'b0;
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b0;
        cmd_UART = 16'h0000;
        cmd_rdy_UART = 1'b0;
        rst_n = 1'b0;
        clear_moves();
        test_reset();
        test_passthrough();
        test_single_move();
        test_south_west();
        test_full_tour();
        test_simultaneous();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
